// File: rtl/i2c_target_if.sv
// I2C target front end: synchronised and glitch-filtered SCL/SDA, START/STOP detection,
// 7-bit address match, write-byte reception and read-byte service via an open-drain SDA pull-down.
//
// state       | meaning
// IDLE        | bus free or not yet addressed
// ADDR        | shifting in address + R/W bit
// ADDR_ACK    | pulling SDA low for the address ACK
// WR          | shifting in a write byte
// WR_ACK      | pulling SDA low for the write-byte ACK
// RD          | driving a read byte, MSB first
// RD_ACK      | sampling the master's ACK/NACK
// WAIT_STOP   | not addressed or read ended; wait for START/STOP
module i2c_target_if #(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2,
    parameter int         FILT        = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);
    localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [FW-1:0] FLOAD = FW'(FILT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_WAIT_STOP
    } state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic [1:0]    raw, filt, filt_q;
    logic [FW-1:0] fcnt [2];
    logic          scl_f, sda_f, scl_q, sda_q;
    logic          rise, fall, start, stop;

    state_t     state, state_nxt;
    logic [2:0] bit_cnt, bit_cnt_nxt;
    logic [7:0] shift, shift_nxt, rx_data_nxt;
    logic       oe_q, oe_nxt, rx_valid_nxt, rx_first_nxt, busy_nxt;
    logic       armed, armed_nxt, phase, phase_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
        end
    end

    assign raw = {scl_sync[SYNC_STAGES-1], sda_sync[SYNC_STAGES-1]};

    // A new level is accepted only after FILT consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt   <= 2'b11;
            filt_q <= 2'b11;
            for (int i = 0; i < 2; i++) fcnt[i] <= FLOAD;
        end else begin
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == filt[i]) begin
                    fcnt[i] <= FLOAD;
                end else if (fcnt[i] == '0) begin
                    filt[i] <= raw[i];
                    fcnt[i] <= FLOAD;
                end else begin
                    fcnt[i] <= fcnt[i] - FW'(1);
                end
            end
        end
    end

    assign scl_f = filt[1];
    assign sda_f = filt[0];
    assign scl_q = filt_q[1];
    assign sda_q = filt_q[0];
    assign rise  = scl_f & ~scl_q;
    assign fall  = ~scl_f & scl_q;
    assign start = scl_f & scl_q & sda_q & ~sda_f;
    assign stop  = scl_f & scl_q & ~sda_q & sda_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            bit_cnt  <= 3'd7;
            shift    <= '0;
            oe_q     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_first <= 1'b0;
            busy     <= 1'b0;
            armed    <= 1'b0;
            phase    <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shift    <= shift_nxt;
            oe_q     <= oe_nxt;
            rx_data  <= rx_data_nxt;
            rx_valid <= rx_valid_nxt;
            rx_first <= rx_first_nxt;
            busy     <= busy_nxt;
            armed    <= armed_nxt;
            phase    <= phase_nxt;
        end
    end

    // tx_req is combinational so tx_data is latched in the very clk the fall is seen.
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift;
        oe_nxt       = oe_q;
        rx_data_nxt  = rx_data;
        rx_valid_nxt = 1'b0;
        rx_first_nxt = rx_first;
        busy_nxt     = busy;
        armed_nxt    = armed;
        phase_nxt    = phase;
        tx_req       = 1'b0;
        if (stop) begin
            state_nxt = S_IDLE;
            oe_nxt    = 1'b0;
            busy_nxt  = 1'b0;
            phase_nxt = 1'b0;
        end else if (start) begin
            state_nxt   = S_ADDR;
            bit_cnt_nxt = 3'd7;
            oe_nxt      = 1'b0;
            phase_nxt   = 1'b0;
        end else begin
            case (state)
                S_IDLE: ;
                S_ADDR: if (rise) begin
                    shift_nxt = {shift[6:0], sda_f};
                    if (bit_cnt == 3'd0) begin
                        phase_nxt = 1'b0;
                        if (shift[6:0] == ADDR) begin
                            state_nxt = S_ADDR_ACK;
                            busy_nxt  = 1'b1;
                        end else begin
                            state_nxt = S_WAIT_STOP;
                            busy_nxt  = 1'b0;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt - 3'd1;
                    end
                end
                S_ADDR_ACK: if (fall) begin
                    if (!phase) begin
                        oe_nxt    = 1'b1;
                        phase_nxt = 1'b1;
                    end else begin
                        phase_nxt   = 1'b0;
                        bit_cnt_nxt = 3'd7;
                        if (shift[0]) begin
                            tx_req    = 1'b1;
                            shift_nxt = {tx_data[6:0], 1'b0};
                            oe_nxt    = ~tx_data[7];
                            state_nxt = S_RD;
                        end else begin
                            oe_nxt    = 1'b0;
                            armed_nxt = 1'b1;
                            state_nxt = S_WR;
                        end
                    end
                end
                S_WR: if (rise) begin
                    shift_nxt = {shift[6:0], sda_f};
                    if (bit_cnt == 3'd0) begin
                        rx_data_nxt  = {shift[6:0], sda_f};
                        rx_valid_nxt = 1'b1;
                        rx_first_nxt = armed;
                        armed_nxt    = 1'b0;
                        phase_nxt    = 1'b0;
                        state_nxt    = S_WR_ACK;
                    end else begin
                        bit_cnt_nxt = bit_cnt - 3'd1;
                    end
                end
                S_WR_ACK: if (fall) begin
                    if (!phase) begin
                        oe_nxt    = 1'b1;
                        phase_nxt = 1'b1;
                    end else begin
                        oe_nxt      = 1'b0;
                        phase_nxt   = 1'b0;
                        bit_cnt_nxt = 3'd7;
                        state_nxt   = S_WR;
                    end
                end
                S_RD: if (fall) begin
                    if (bit_cnt == 3'd0) begin
                        oe_nxt    = 1'b0;
                        phase_nxt = 1'b0;
                        state_nxt = S_RD_ACK;
                    end else begin
                        bit_cnt_nxt = bit_cnt - 3'd1;
                        shift_nxt   = {shift[6:0], 1'b0};
                        oe_nxt      = ~shift[7];
                    end
                end
                S_RD_ACK: begin
                    if (rise && !phase) begin
                        if (sda_f) begin
                            state_nxt = S_WAIT_STOP;
                            busy_nxt  = 1'b0;
                        end else begin
                            phase_nxt = 1'b1;
                        end
                    end else if (fall && phase) begin
                        tx_req      = 1'b1;
                        shift_nxt   = {tx_data[6:0], 1'b0};
                        oe_nxt      = ~tx_data[7];
                        bit_cnt_nxt = 3'd7;
                        phase_nxt   = 1'b0;
                        state_nxt   = S_RD;
                    end
                end
                S_WAIT_STOP: oe_nxt = 1'b0;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign sda_oe = oe_q & ~start & ~stop;

endmodule
